// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared FSM state, default WS2812 timing and GRB pixel layout
package ws2812_pkg;
   typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;
   localparam int DEF_T0H    = 4;
   localparam int DEF_T1H    = 8;
   localparam int DEF_TBIT   = 12;
   localparam int DEF_TLATCH = 3000;
   localparam int DEF_CW     = 12;
   typedef struct packed {
      logic [7:0] g;
      logic [7:0] r;
      logic [7:0] b;
   } pixel_t;
endpackage

// File: rtl/ws2812_tx.sv
// ws2812_tx: WS2812 bit serializer; GRB pixels in over valid/ready (in_valid, in_ready, in_grb, in_last), registered LED line dout, status busy/underrun/frame_done
module ws2812_tx
   import ws2812_pkg::*;
#(
   parameter int T0H    = DEF_T0H,
   parameter int T1H    = DEF_T1H,
   parameter int TBIT   = DEF_TBIT,
   parameter int TLATCH = DEF_TLATCH,
   parameter int CW     = DEF_CW
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [23:0] in_grb,
   input  logic        in_last,
   output logic        dout,
   output logic        busy,
   output logic        underrun,
   output logic        frame_done
);
   state_t        state_q, state_d;
   pixel_t        sr_q, sr_d;
   logic [4:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_q, last_d;
   logic          dout_q, dout_d;
   logic          underrun_q, underrun_d;
   logic          frame_done_q, frame_done_d;
   logic          bit_end, px_end, take;

   assign bit_end = cnt_q == CW'(TBIT - 1);
   assign px_end  = bit_end && idx_q == 5'd0;
   assign take    = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         sr_q         <= '0;
         idx_q        <= '0;
         cnt_q        <= '0;
         last_q       <= 1'b0;
         dout_q       <= 1'b0;
         underrun_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         last_q       <= last_d;
         dout_q       <= dout_d;
         underrun_q   <= underrun_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      last_d       = last_q;
      underrun_d   = 1'b0;
      frame_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (take) begin
               state_d = SEND;
               sr_d    = pixel_t'(in_grb);
               idx_d   = 5'd23;
               cnt_d   = '0;
               last_d  = in_last;
            end
         end
         SEND: begin
            if (!bit_end) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               cnt_d = '0;
               if (!px_end) begin
                  idx_d = idx_q - 5'd1;
                  sr_d  = pixel_t'({sr_q[22:0], 1'b0});
               end else if (take) begin
                  // back-to-back pixel: next bit starts on the very next cycle
                  sr_d   = pixel_t'(in_grb);
                  idx_d  = 5'd23;
                  last_d = in_last;
               end else if (!last_q) begin
                  underrun_d = 1'b1;
                  state_d    = IDLE;
               end else begin
                  state_d = LATCH;
               end
            end
         end
         LATCH: begin
            if (cnt_q == CW'(TLATCH - 1)) begin
               cnt_d        = '0;
               frame_done_d = 1'b1;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      // evaluated on next-cycle values so dout_q lines up with cnt_q/sr_q
      dout_d = state_d == SEND && cnt_d < (sr_d.g[7] ? CW'(T1H) : CW'(T0H));
   end

   always_comb begin
      // gated by rst so in_ready reads low while reset is held
      in_ready = rst && (state_q == IDLE || (state_q == SEND && px_end && !last_q));
      busy     = state_q != IDLE;
   end

   assign dout       = dout_q;
   assign underrun   = underrun_q;
   assign frame_done = frame_done_q;
endmodule

// File: tb/tb_ws2812_tx.sv
// tb_ws2812_tx: scoreboard bench decoding dout back into pixels for ws2812_tx
module tb_ws2812_tx;
   localparam int T0H = 4, T1H = 8, TBIT = 12, TLATCH = 3000;
   localparam int PX = 24 * TBIT;

   logic        clk, rst, in_valid, in_ready, in_last;
   logic [23:0] in_grb;
   logic        dout, busy, underrun, frame_done;

   int n_err = 0, n_checks = 0;
   int cyc = 0, busy_cnt = 0, un_cnt = 0, fd_cnt = 0;
   int bad_pulse = 0, bad_period = 0, last_rise = 0, hcnt = 0, nbits = 0;
   bit rise_ok = 0;
   logic prev_dout = 1'b0;
   logic [23:0] acc = '0, exp_px;
   logic [23:0] exp_q[$];

   ws2812_tx dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_grb(in_grb), .in_last(in_last), .dout(dout), .busy(busy),
      .underrun(underrun), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // scoreboard: push accepted pixels, decode dout pulses, pop per 24 bits
   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         hcnt = 0; nbits = 0; acc = '0; rise_ok = 0; prev_dout = 1'b0;
      end else begin
         if (in_valid && in_ready) exp_q.push_back(in_grb);
         if (busy) busy_cnt++;
         if (underrun) un_cnt++;
         if (frame_done) fd_cnt++;
         if (!busy) rise_ok = 0;
         if (dout && !prev_dout) begin
            if (rise_ok && cyc - last_rise != TBIT) bad_period++;
            last_rise = cyc;
            rise_ok = 1;
         end
         if (dout) hcnt++;
         else if (hcnt > 0) begin
            if (hcnt != T0H && hcnt != T1H) bad_pulse++;
            acc = {acc[22:0], hcnt > (T0H + T1H) / 2};
            hcnt = 0;
            nbits++;
            if (nbits == 24) begin
               nbits = 0;
               if (exp_q.size() == 0) check("px_extra", 1, 0);
               else begin
                  exp_px = exp_q.pop_front();
                  check("px", {8'h0, acc}, {8'h0, exp_px});
               end
            end
         end
         prev_dout = dout;
      end
   end

   task automatic drive_px(input logic [23:0] px, input logic last, output int hs);
      int n = 0;
      in_grb = px; in_last = last; in_valid = 1'b1;
      do begin @(negedge clk); n++; end while (!in_ready && n < 4000);
      if (!in_ready) begin check("hs_timeout", 0, 1); hs = -1; end
      else hs = cyc;
      @(posedge clk); #1;
   endtask

   task automatic wait_fd(input int bound);
      bit seen = 0;
      for (int n = 0; n < bound && !seen; n++) begin
         @(negedge clk);
         seen = frame_done;
      end
      if (!seen) check("fd_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int hs1, hs2, fd0, un0, nbig, g;
      bit un_seen;
      rst = 1'b0; in_valid = 1'b0; in_grb = '0; in_last = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_dout", dout, 0);
      check("rst_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_underrun", underrun, 0);
      check("rst_frame_done", frame_done, 0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("rel_ready", in_ready, 1);
      @(posedge clk); #1;

      // single pixel, last
      busy_cnt = 0; fd0 = fd_cnt;
      drive_px(24'hFF0000, 1'b1, hs1);
      in_valid = 1'b0; in_grb = 24'h5A5A5A; in_last = 1'b0;
      wait_fd(4000);
      check("t1_busy", busy_cnt, PX + TLATCH);
      repeat (20) @(negedge clk);
      check("t1_fd_once", fd_cnt - fd0, 1);
      @(posedge clk); #1;

      // two pixels back to back
      busy_cnt = 0;
      drive_px(24'h000001, 1'b0, hs1);
      drive_px(24'h800000, 1'b1, hs2);
      in_valid = 1'b0;
      check("t2_accept_idx", hs2 - hs1 - 1, PX - 1);
      wait_fd(4000);
      check("t2_busy", busy_cnt, 2 * PX + TLATCH);
      check("t2_no_gap", bad_period, 0);

      // starvation mid-frame
      fd0 = fd_cnt; un0 = un_cnt;
      drive_px(24'hAAAAAA, 1'b0, hs1);
      in_valid = 1'b0;
      un_seen = 0;
      for (int n = 0; n < 400 && !un_seen; n++) begin
         @(negedge clk);
         un_seen = underrun;
      end
      check("t3_underrun_seen", un_seen, 1);
      check("t3_underrun_idx", cyc - hs1 - 1, PX);
      check("t3_busy", busy, 0);
      check("t3_dout", dout, 0);
      check("t3_ready", in_ready, 1);
      repeat (50) @(negedge clk);
      check("t3_no_fd", fd_cnt - fd0, 0);
      check("t3_one_underrun", un_cnt - un0, 1);
      @(posedge clk); #1;

      // valid held during LATCH is only taken in the first IDLE cycle
      fd0 = fd_cnt;
      drive_px(24'h123456, 1'b1, hs1);
      drive_px(24'h654321, 1'b1, hs2);
      in_valid = 1'b0;
      check("t4_accept_after", hs2 - hs1, PX + TLATCH + 1);
      check("t4_fd_before", fd_cnt - fd0, 1);
      wait_fd(4000);

      // asynchronous reset mid-bit
      fd0 = fd_cnt; un0 = un_cnt;
      drive_px(24'hFFFFFF, 1'b1, hs1);
      in_valid = 1'b0;
      repeat (100) @(negedge clk);
      check("t5_dout_pre", dout, 1);
      #2 rst = 1'b0;
      #1;
      check("t5_dout_async", dout, 0);
      check("t5_busy_async", busy, 0);
      check("t5_ready_async", in_ready, 0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst = 1'b1;
      repeat (10) @(negedge clk);
      check("t5_no_pulses", (fd_cnt - fd0) + (un_cnt - un0), 0);
      @(posedge clk); #1;
      drive_px(24'h0F0F0F, 1'b1, hs1);
      in_valid = 1'b0;
      wait_fd(4000);
      check("t5_fd_after", fd_cnt - fd0, 1);

      // randomised gaps, occasionally long enough to starve
      un0 = un_cnt; nbig = 0;
      for (int i = 0; i < 64; i++) begin
         drive_px(24'($urandom), i == 63, hs1);
         in_valid = 1'b0;
         if (i < 63) begin
            g = ($urandom_range(0, 7) == 0) ? 320 : $urandom_range(0, 20);
            if (g > PX) nbig++;
            repeat (g) @(posedge clk);
            #1;
         end
      end
      wait_fd(4000);
      check("t6_underruns", un_cnt - un0, nbig);

      repeat (5) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      check("pulse_width", bad_pulse, 0);
      check("bit_period", bad_period, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/ws2812_tx.md
Name: ws2812_tx

Overview:
- Bit-level serializer for WS2812-class addressable LEDs. Drives the single-wire LED data line on PMOD[44].
- Consumes 24-bit GRB pixels over a valid/ready handshake from the light controller. That controller fetches pixel words from SRAM port C.
- Generates the T0H/T1H/bit-period waveform and the end-of-frame latch gap in the 10 MHz divided clock domain.

Parameters:
- T0H, 4: high cycles for a 0 bit (0.4 us at 10 MHz).
- T1H, 8: high cycles for a 1 bit (0.8 us).
- TBIT, 12: total cycles per bit (1.2 us). Requires T0H < T1H < TBIT.
- TLATCH, 3000: low cycles after a frame's last pixel (300 us, covers newer parts).
- CW, 12: counter width; must hold max(TBIT, TLATCH).

Ports:
- clk, input, 1: system clock (10 MHz divided clock).
- rst, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: pixel present on in_grb/in_last.
- in_ready, output, 1: block accepts the pixel this cycle when high with in_valid.
- in_grb, input, 24: pixel. [23:16]=G, [15:8]=R, [7:0]=B.
- in_last, input, 1: pixel is the final pixel of a frame.
- dout, output, 1: LED data line, registered.
- busy, output, 1: high in any state except IDLE.
- underrun, output, 1: one-cycle pulse on a mid-frame starvation.
- frame_done, output, 1: one-cycle pulse when the latch gap completes.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, dout=0, in_ready=0, busy=0, underrun=0, frame_done=0, counters=0, shift register=0.
  - The first cycle after release has in_ready=1.
- States: IDLE, SEND, LATCH.
- IDLE:
  - in_ready=1, dout=0.
  - A handshake loads in_grb into the shift register, bit index=23, bit counter=0, stores in_last, and moves to SEND.
- SEND:
  - The bit counter runs 0..TBIT-1.
  - dout registered = (cnt < (cur_bit ? T1H : T0H)).
  - dout rises on the cycle after the accepting handshake (latency 1).
  - Bit order is MSB first: G7..G0, R7..R0, B7..B0.
  - At cnt=TBIT-1, the bit index decrements.
- Pixel boundary (bit index 0, cnt=TBIT-1):
  - in_ready=1 in this cycle only while in SEND.
  - If the stored last=0 and in_valid=1: load the next pixel, stay in SEND. The next bit starts without a gap.
  - If the stored last=0 and in_valid=0: pulse underrun, go to IDLE. dout stays 0; the LED may latch a partial frame, which is accepted.
  - If the stored last=1: in_ready=0, go to LATCH, counter=0.
- LATCH:
  - dout=0, in_ready=0.
  - The counter counts to TLATCH-1, then frame_done pulses and the state goes to IDLE.
  - in_valid held high during LATCH is not accepted.
- in_ready is registered-combinational from state and counter only, never from in_valid.
- in_grb and in_last are sampled only on the handshake. Changes at other times are ignored.
- A frame of N pixels occupies N*24*TBIT cycles plus TLATCH cycles when fed with no bubbles.
- Reset asserted mid-bit: dout drops to 0 immediately (asynchronous). The partial pixel is discarded; no underrun or frame_done pulse.
- Counter arithmetic is unsigned CW-bit. Comparisons are against parameters zero-extended to CW.

Decomposition:
- Shared package ws2812_pkg:
  - State enum (IDLE/SEND/LATCH).
  - Default timing constants T0H/T1H/TBIT/TLATCH.
  - The 24-bit pixel typedef with g/r/b byte fields.
- No sub-module is needed; a single FSM with a shift register and two counters is the natural structure.
- The light controller instantiates ws2812_tx and wires dout to PMOD[44].

Test Plan:
- Single pixel 24'hFF0000, in_last=1 → dout shows 8 bits at 8H/4L, then 16 bits at 4H/8L.
  - busy held for 288+3000 cycles, then frame_done pulses once.
- Two pixels 24'h000001 then 24'h800000 (last), in_valid held high:
  - Second pixel accepted exactly at cycle 287 after the first is accepted.
  - No dout gap: the bit-23 high of pixel 2 directly follows the bit-0 low of pixel 1.
  - Total busy time 576+3000 cycles.
- Pixel 24'hAAAAAA with in_last=0 and in_valid then dropped → underrun pulses at cycle 288, state returns to IDLE, dout=0, no frame_done.
- in_valid held high with new data during LATCH → in_ready stays 0 for 3000 cycles; the pixel is accepted on the first IDLE cycle.
- Reset asserted at cycle 100 of pixel 24'hFFFFFF → dout=0 asynchronously, busy=0. After release, a fresh pixel 24'h0F0F0F transmits correctly from bit 23.
- Randomised valid gaps across 64 pixels → captured dout decodes to the input sequence whenever no underrun occurred.
